// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite read master port among S_COUNT requesters.
// One transaction is in flight at a time; each R beat is steered back to the granted port.
module axil_rd_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [S_COUNT*3-1:0]          s_axil_arprot,
    input  logic [S_COUNT-1:0]            s_axil_arvalid,
    output logic [S_COUNT-1:0]            s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
    output logic [S_COUNT*2-1:0]          s_axil_rresp,
    output logic [S_COUNT-1:0]            s_axil_rvalid,
    input  logic [S_COUNT-1:0]            s_axil_rready,
    output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
    output logic [2:0]                    m_axil_arprot,
    output logic                          m_axil_arvalid,
    input  logic                          m_axil_arready,
    input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
    input  logic [1:0]                    m_axil_rresp,
    input  logic                          m_axil_rvalid,
    output logic                          m_axil_rready
);
    localparam int GW = $clog2(S_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_READ = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [2:0]            arprot_q, arprot_d;
    logic                  arvalid_q, arvalid_d;

    logic                  sel_valid_s;
    logic [GW-1:0]         sel_idx_s;

    // Rotating priority search: scanned farthest-first so the nearest port after ptr_q wins.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        for (int k = S_COUNT; k >= 1; k--) begin
            if (s_axil_arvalid[GW'((int'(ptr_q) + k) % S_COUNT)]) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = GW'((int'(ptr_q) + k) % S_COUNT);
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Transaction sequencing and capture of the granted request into the master AR register.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        araddr_d  = araddr_q;
        arprot_d  = arprot_q;
        arvalid_d = arvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid_s) begin
                    grant_d   = sel_idx_s;
                    ptr_d     = sel_idx_s;
                    araddr_d  = s_axil_araddr[sel_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                    arprot_d  = s_axil_arprot[sel_idx_s*3 +: 3];
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_READ;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_READ: begin
                if (m_axil_rvalid && m_axil_rready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Requester-side handshakes; AR ready is suppressed while reset is held so nothing is accepted.
    always_comb begin
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        m_axil_rready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid_s && !rst) begin
                    s_axil_arready[sel_idx_s] = 1'b1;
                end else begin
                    s_axil_arready = '0;
                end
            end
            ST_READ: begin
                s_axil_rvalid[grant_q] = m_axil_rvalid;
                m_axil_rready          = s_axil_rready[grant_q];
            end
            default: begin
                m_axil_rready = 1'b0;
            end
        endcase
    end

    // State and AR register; ptr_q resets to the last port so port 0 is first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= GW'(S_COUNT - 1);
            araddr_q  <= '0;
            arprot_q  <= 3'd0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            araddr_q  <= araddr_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = arprot_q;
    assign m_axil_arvalid = arvalid_q;
    assign s_axil_rdata   = {S_COUNT{m_axil_rdata}};
    assign s_axil_rresp   = {S_COUNT{m_axil_rresp}};

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and an echoing slave.
module tb_axil_rd_arbiter;
    localparam int S  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [S*AW-1:0] s_araddr;
    logic [S*3-1:0]  s_arprot;
    logic [S-1:0]    s_arvalid;
    logic [S-1:0]    s_arready;
    logic [S*DW-1:0] s_rdata;
    logic [S*2-1:0]  s_rresp;
    logic [S-1:0]    s_rvalid;
    logic [S-1:0]    s_rready;
    logic [AW-1:0]   m_araddr;
    logic [2:0]      m_arprot;
    logic            m_arvalid;
    logic            m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rvalid;
    logic            m_rready;

    always #5 clk = ~clk;

    axil_rd_arbiter #(.S_COUNT(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid),
        .s_axil_arready(s_arready), .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
        .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
        .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid),
        .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
        .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester state and stimulus knobs.
    logic          req_v    [S];
    logic [AW-1:0] req_addr [S];
    logic [2:0]    req_prot [S];
    int gen_pct, drop_pct, rready_pct, arready_pct, rdelay_max, spur_pct;
    logic [1:0]    resp_val;
    bit            resp_rand, echo;
    logic [DW-1:0] fixed_data;

    // Slave model: echoes the accepted address (or fixed_data) after a random delay.
    bit            sl_pend;
    int            sl_delay;
    logic [DW-1:0] sl_data;
    logic [1:0]    sl_resp;

    // Reference model: transaction-level view of the arbiter.
    bit            mdl_busy, mdl_sent;
    int            mdl_owner, mdl_last;
    logic [AW-1:0] mdl_addr;
    logic [2:0]    mdl_prot;
    logic [DW-1:0] mdl_data;
    int            n_done, n_grant, last_grant;
    int            wait_cnt [S];
    int            grant_log [$];
    logic [DW-1:0] got_data;
    logic [1:0]    got_resp;
    logic [S-1:0]  got_rvalid;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mdl_busy = 1'b0;
        mdl_sent = 1'b0;
        mdl_last = S - 1;
        sl_pend  = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model and slave.
    task automatic step();
        int           w;
        logic [S-1:0] exp_arready, exp_rvalid;
        logic         exp_arvalid, exp_rready;
        bit           r_hs;
        for (int i = 0; i < S; i++) begin
            if (!req_v[i]) begin
                if ($urandom_range(99) < gen_pct) begin
                    req_v[i]    = 1'b1;
                    req_addr[i] = $urandom;
                    req_prot[i] = 3'($urandom);
                end
            end else if ($urandom_range(99) < drop_pct) begin
                req_v[i]    = 1'b0;
                wait_cnt[i] = 0;
            end
            s_arvalid[i]         = req_v[i];
            s_araddr[i*AW +: AW] = req_addr[i];
            s_arprot[i*3 +: 3]   = req_prot[i];
            s_rready[i]          = $urandom_range(99) < rready_pct;
        end
        m_arready = $urandom_range(99) < arready_pct;
        if (sl_pend && sl_delay == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = sl_data;
            m_rresp  = sl_resp;
        end else begin
            m_rvalid = !sl_pend && ($urandom_range(99) < spur_pct);
            m_rdata  = $urandom;
            m_rresp  = 2'($urandom);
        end
        #1;
        w = -1;
        if (!mdl_busy)
            for (int k = S; k >= 1; k--)
                if (req_v[(mdl_last + k) % S]) w = (mdl_last + k) % S;
        exp_arready = '0;
        if (w >= 0) exp_arready[w] = 1'b1;
        exp_arvalid = mdl_busy && !mdl_sent;
        exp_rvalid  = '0;
        exp_rready  = 1'b0;
        if (mdl_busy && mdl_sent) begin
            exp_rready            = s_rready[mdl_owner];
            exp_rvalid[mdl_owner] = m_rvalid;
        end
        chk_eq("arready", s_arready, exp_arready);
        chk_eq("m_arvalid", m_arvalid, exp_arvalid);
        if (exp_arvalid) begin
            chk_eq("m_araddr", m_araddr, mdl_addr);
            chk_eq("m_arprot", m_arprot, mdl_prot);
        end
        chk_eq("rvalid", s_rvalid, exp_rvalid);
        chk_eq("m_rready", m_rready, exp_rready);
        chk_eq("rdata_rep", s_rdata, {S{m_rdata}});
        chk_eq("rresp_rep", s_rresp, {S{m_rresp}});
        r_hs = mdl_busy && mdl_sent && m_rvalid && exp_rready;
        if (w >= 0) begin
            for (int i = 0; i < S; i++)
                if (i != w && req_v[i]) wait_cnt[i]++;
            chk_eq("starve", wait_cnt[w] <= S - 1, 1'b1);
            wait_cnt[w] = 0;
            grant_log.push_back(w);
            n_grant++;
            last_grant = w;
            mdl_busy   = 1'b1;
            mdl_sent   = 1'b0;
            mdl_owner  = w;
            mdl_last   = w;
            mdl_addr   = req_addr[w];
            mdl_prot   = req_prot[w];
            mdl_data   = echo ? req_addr[w] : fixed_data;
            req_v[w]   = 1'b0;
        end else if (exp_arvalid && m_arready) begin
            mdl_sent = 1'b1;
        end else if (r_hs) begin
            got_data   = s_rdata[mdl_owner*DW +: DW];
            got_resp   = s_rresp[mdl_owner*2 +: 2];
            got_rvalid = s_rvalid;
            chk_eq("r_data", got_data, mdl_data);
            chk_eq("r_resp", got_resp, sl_resp);
            mdl_busy = 1'b0;
            n_done++;
        end
        if (m_arvalid && m_arready && !sl_pend) begin
            sl_pend  = 1'b1;
            sl_data  = echo ? m_araddr : fixed_data;
            sl_delay = $urandom_range(rdelay_max, 0);
            sl_resp  = resp_rand ? 2'($urandom) : resp_val;
        end else if (sl_pend && sl_delay > 0) begin
            sl_delay--;
        end else if (sl_pend && m_rvalid && m_rready) begin
            sl_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic [2:0] pr);
        req_v[p]    = 1'b1;
        req_addr[p] = a;
        req_prot[p] = pr;
    endtask

    initial begin
        int n0, g0;
        logic [AW-1:0] a0;
        for (int i = 0; i < S; i++) begin
            req_v[i] = 1'b0; req_addr[i] = '0; req_prot[i] = 3'd0; wait_cnt[i] = 0;
        end
        gen_pct = 0; drop_pct = 0; rready_pct = 100; arready_pct = 100; rdelay_max = 0;
        spur_pct = 0; resp_val = 2'b00; resp_rand = 1'b0; echo = 1'b1; fixed_data = '0;
        n_done = 0; n_grant = 0; last_grant = -1;
        got_data = '0; got_resp = 2'b00; got_rvalid = '0;
        model_reset();

        // Reset state, with requests and R traffic present while reset is held.
        rst = 1'b1;
        s_arvalid = {S{1'b1}}; s_araddr = {S{32'hA5A5_0000}}; s_arprot = {S{3'd7}};
        s_rready = {S{1'b1}}; m_arready = 1'b1; m_rvalid = 1'b1;
        m_rdata = 32'h1234_5678; m_rresp = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_arready", s_arready, 4'b0000);
        chk_eq("rst_m_arvalid", m_arvalid, 1'b0);
        chk_eq("rst_m_araddr", m_araddr, 32'h0);
        chk_eq("rst_m_arprot", m_arprot, 3'd0);
        chk_eq("rst_m_rready", m_rready, 1'b0);
        chk_eq("rst_rvalid", s_rvalid, 4'b0000);
        rst = 1'b0;
        model_reset();

        // Single request from port 2 with fixed read data; stray rvalid while idle.
        echo = 1'b0; fixed_data = 32'hDEAD_BEEF; spur_pct = 100;
        set_req(2, 32'h0000_1004, 3'd5);
        step();
        chk_eq("t1_araddr", m_araddr, 32'h0000_1004);
        chk_eq("t1_arvalid", m_arvalid, 1'b1);
        step();
        step();
        chk_eq("t1_done", n_done, 1);
        chk_eq("t1_grant", last_grant, 2);
        chk_eq("t1_rdata", got_data, 32'hDEAD_BEEF);
        chk_eq("t1_rvalid", got_rvalid, 4'b0100);
        echo = 1'b1; spur_pct = 0;

        // All ports continuously valid, zero-wait slave: strict rotation from port 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        grant_log.delete();
        n0 = n_done;
        gen_pct = 100;
        repeat (24) step();
        chk_eq("t2_count", grant_log.size(), 8);
        for (int k = 0; k < 8; k++)
            chk_eq($sformatf("t2_grant%0d", k), (grant_log.size() > k) ? grant_log[k] : -1, k % 4);
        chk_eq("t2_done", n_done - n0, 8);

        // Backpressure on AR and R; a second requester must wait.
        gen_pct = 0;
        for (int i = 0; i < S; i++) req_v[i] = 1'b0;
        repeat (2) step();
        n0 = n_done;
        arready_pct = 0; rready_pct = 0;
        set_req(1, 32'h0000_2000, 3'd2);
        step();
        a0 = m_araddr;
        chk_eq("t3_araddr", a0, 32'h0000_2000);
        set_req(3, 32'h0000_3000, 3'd1);
        repeat (5) step();
        chk_eq("t3_araddr_stable", m_araddr, 32'h0000_2000);
        arready_pct = 100;
        repeat (4) step();
        chk_eq("t3_rvalid_held", s_rvalid, 4'b0010);
        chk_eq("t3_no_arready", s_arready, 4'b0000);
        chk_eq("t3_not_done", n_done - n0, 0);
        rready_pct = 100;
        step();
        chk_eq("t3_one_done", n_done - n0, 1);
        step();
        chk_eq("t3_next_grant", last_grant, 3);
        repeat (2) step();

        // Error response passes through; next request served normally.
        n0 = n_done;
        resp_val = 2'b10;
        set_req(1, 32'h0000_4000, 3'd0);
        repeat (3) step();
        chk_eq("t4_resp", got_resp, 2'b10);
        chk_eq("t4_rvalid", got_rvalid, 4'b0010);
        resp_val = 2'b00;
        set_req(0, 32'h0000_4100, 3'd0);
        repeat (3) step();
        chk_eq("t4_resp_next", got_resp, 2'b00);
        chk_eq("t4_rvalid_next", got_rvalid, 4'b0001);
        chk_eq("t4_done", n_done - n0, 2);

        // Reset while in the address phase, then port 0 beats port 3.
        arready_pct = 0;
        set_req(2, 32'h0000_5000, 3'd3);
        step();
        chk_eq("t5_arvalid_pre", m_arvalid, 1'b1);
        #2;
        rst = 1'b1;
        set_req(0, 32'h0000_6000, 3'd4);
        set_req(3, 32'h0000_7000, 3'd6);
        s_arvalid = 4'b1001;
        s_araddr[0 +: AW] = 32'h0000_6000; s_araddr[3*AW +: AW] = 32'h0000_7000;
        #1;
        chk_eq("t5_arvalid_rst", m_arvalid, 1'b0);
        chk_eq("t5_arready_rst", s_arready, 4'b0000);
        chk_eq("t5_rvalid_rst", s_rvalid, 4'b0000);
        @(posedge clk);
        #1;
        chk_eq("t5_arready_rst2", s_arready, 4'b0000);
        rst = 1'b0;
        model_reset();
        req_v[2] = 1'b0;
        arready_pct = 100;
        step();
        chk_eq("t5_grant0", last_grant, 0);
        repeat (3) step();
        chk_eq("t5_grant3", last_grant, 3);
        repeat (2) step();

        // Randomized traffic on all ports.
        n0 = n_done; g0 = n_grant;
        gen_pct = 30; drop_pct = 5; rready_pct = 70; arready_pct = 60;
        rdelay_max = 3; spur_pct = 20; resp_rand = 1'b1;
        repeat (10000) step();
        gen_pct = 0; drop_pct = 0; rready_pct = 100; arready_pct = 100; spur_pct = 0;
        for (int i = 0; i < S; i++) req_v[i] = 1'b0;
        repeat (10) step();
        chk_eq("rand_r_per_ar", n_done - n0, n_grant - g0);
        chk_eq("rand_active", (n_grant - g0) > 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
